sysmgr_rst_seq: RTL and testbench
=================================

// Module: sysmgr_rst_seq
//
// PURPOSE
//  Parametrised reset sequencer for the system manager. It drives the PLL reset and
//  watches PLL lock with a glitch filter, retrying the PLL after a lock timeout. It then
//  releases N_RST reset outputs one after another in a fixed order.
//  It runs on the free-running reference clock, never a PLL output, and sits between the
//  PLL and the per-domain reset synchronisers and global buffers.
//
// PARAMETERS
//  N_RST        3   number of sequenced reset outputs (1..8)
//  PLL_RST_CYC  8   cycles pll_reset_n is held low per PLL reset attempt (>=2)
//  LOCK_FILT    4   synced lock must be high 2**LOCK_FILT consecutive cycles -> lock_ok
//  STAGE_DLY_W  4   gap between successive rst_out releases = 2**STAGE_DLY_W cycles
//  LOCK_TMO_W   16  WAIT_LOCK timeout = 2**LOCK_TMO_W cycles, then PLL is retried
//
// PORTS
//  clk          in   1      reference clock; only clock of the block
//  rst_n        in   1      asynchronous, active-low reset
//  pll_lock     in   1      PLL LOCK, asynchronous to clk; 2-FF synchronised inside
//  sw_rst_req   in   1      clk-synchronous 1-cycle pulse: full re-sequence incl. PLL
//  pll_reset_n  out  1      to PLL RESETB (active-low)
//  rst_out      out  N_RST  active-high resets; bit 0 is released first
//  ready        out  1      high only in RUN (all rst_out released)
//  lock_lost    out  1      sticky: lock dropped while in RELEASE/RUN
//  retry_cnt    out  4      count of WAIT_LOCK timeouts, saturates at 15
//
// BEHAVIOUR
//  - Reset values (rst_n low, effective immediately): pll_reset_n=0, rst_out=all 1,
//    ready=0, lock_lost=0, retry_cnt=0, FSM=PLL_RST, all counters 0. All outputs registered.
//  - lock_s = pll_lock through a 2-FF synchroniser. Filter counter clears on any lock_s=0
//    and counts up on lock_s=1. lock_ok=1 while the counter is saturated at 2**LOCK_FILT.
//  - FSM:
//    PLL_RST: pll_reset_n=0 for PLL_RST_CYC cycles, then go to WAIT_LOCK.
//      The filter counter is held clear in this state.
//    WAIT_LOCK: pll_reset_n=1 and rst_out=all 1. On lock_ok, go to RELEASE.
//      After 2**LOCK_TMO_W cycles without lock_ok: retry_cnt += 1 (saturating) and go to PLL_RST.
//    RELEASE: the stage timer counts from 0. rst_out[i] falls exactly
//      (i+1)*2**STAGE_DLY_W cycles after entry. Bits fall one per stage and never re-rise
//      in this state. When bit N_RST-1 falls, go to RUN.
//    RUN: rst_out=0 and ready=1. Stay here until lock is lost or sw_rst_req is seen.
//  - Lock loss (lock_s=0 in RELEASE or RUN):
//    - next cycle: rst_out=all 1, ready=0, lock_lost=1, go to WAIT_LOCK (no PLL reset).
//    - worst-case pll_lock-fall to rst_out-rise is 3 clk cycles.
//  - sw_rst_req=1 in any state: lock_lost clears, rst_out=all 1 and ready=0 on the next
//    cycle, and the FSM goes to PLL_RST with its cycle counter restarted.
//    A request arriving during PLL_RST restarts the PLL_RST count. retry_cnt is not cleared.
//  - Priority: sw_rst_req > lock loss > timeout/stage advance.
//  - Glitches on pll_lock shorter than 2**LOCK_FILT cycles never produce a RELEASE.
//    In RELEASE/RUN a single low synced sample is treated as lock loss (no filtering on the way down).
//  - The timeout counter is LOCK_TMO_W+1 bits wide and clears on every entry to WAIT_LOCK.
//    No counter wraps: each one saturates or is cleared on state entry.
//  - Outputs leave the block unbuffered. The instantiating level adds global buffers
//    and, for foreign clock domains, async-assert/sync-deassert stretchers.
//
// STRUCTURE
//  - No shared package. State encoding (PLL_RST, WAIT_LOCK, RELEASE, RUN) is in localparams.
//  - One sub-module, sync_2ff: a 2-flop synchroniser with async active-low clear,
//    used for pll_lock.
//  - Body: one FSM plus four counters (PLL reset, lock filter, stage timer, timeout).
//
// TESTING  (N_RST=3, PLL_RST_CYC=4, LOCK_FILT=2, STAGE_DLY_W=2, LOCK_TMO_W=6)
//  1. Release rst_n, pll_lock=1 from cycle 10 -> pll_reset_n low for exactly 4 cycles.
//     rst_out[0],[1],[2] fall 4, 8 and 12 cycles after lock_ok; ready rises with [2].
//  2. pll_lock held 0 -> retry_cnt reaches 1 after 4+64 cycles, with a fresh 4-cycle
//     pll_reset_n low pulse each retry. retry_cnt saturates at 15 and never wraps.
//  3. pll_lock glitch high for 3 cycles during WAIT_LOCK -> no rst_out change, ready stays 0.
//  4. In RUN, drop pll_lock for 1 cycle -> rst_out=3'b111 within 3 cycles, lock_lost=1,
//     pll_reset_n stays 1. Re-sequence after relock gives the same timing as test 1.
//  5. sw_rst_req pulse in RELEASE after rst_out[0] has fallen -> next cycle rst_out=3'b111
//     and lock_lost=0, then a 4-cycle pll_reset_n pulse. A second pulse mid-PLL_RST
//     restarts the 4-cycle count.
//  6. Assert rst_n low in RUN -> all outputs return to their reset values asynchronously,
//     and the full sequence repeats after release.

Source files
------------

// File: rtl/sysmgr_rst_seq_sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level signal.
//   clk    in  destination clock
//   rst_n  in  asynchronous active-low clear (both flops clear to 0)
//   d      in  asynchronous input
//   q      out synchronised output, two clk cycles of latency
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sysmgr_rst_seq.sv
// sysmgr_rst_seq: reset sequencer for the system manager, clocked by the
// free-running reference clock. Resets the PLL, waits for a filtered lock
// (retrying the PLL on timeout), then releases the rst_out bits in order.
//   clk          in   reference clock
//   rst_n        in   asynchronous active-low reset
//   pll_lock     in   PLL lock, asynchronous, synchronised internally
//   sw_rst_req   in   1-cycle pulse: full re-sequence including the PLL
//   pll_reset_n  out  PLL RESETB (active-low)
//   rst_out      out  active-high resets, bit 0 released first
//   ready        out  high only while all rst_out bits are released (RUN)
//   lock_lost    out  sticky flag: lock dropped during RELEASE/RUN
//   retry_cnt    out  number of lock timeouts, saturating at 15
module sysmgr_rst_seq #(
    parameter int N_RST       = 3,
    parameter int PLL_RST_CYC = 8,
    parameter int LOCK_FILT   = 4,
    parameter int STAGE_DLY_W = 4,
    parameter int LOCK_TMO_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_lock,
    input  logic             sw_rst_req,
    output logic             pll_reset_n,
    output logic [N_RST-1:0] rst_out,
    output logic             ready,
    output logic             lock_lost,
    output logic [3:0]       retry_cnt
);

    localparam logic [1:0] ENC_PLL_RST   = 2'd0;
    localparam logic [1:0] ENC_WAIT_LOCK = 2'd1;
    localparam logic [1:0] ENC_RELEASE   = 2'd2;
    localparam logic [1:0] ENC_RUN       = 2'd3;

    typedef enum logic [1:0] {
        PLL_RST   = ENC_PLL_RST,
        WAIT_LOCK = ENC_WAIT_LOCK,
        RELEASE   = ENC_RELEASE,
        RUN       = ENC_RUN
    } state_t;

    localparam int PLL_CW = $clog2(PLL_RST_CYC + 1);
    localparam int FILT_W = LOCK_FILT + 1;
    // Up to 8 stages of 2**STAGE_DLY_W cycles: needs STAGE_DLY_W+4 bits.
    localparam int STG_W  = STAGE_DLY_W + 4;
    localparam int TMO_W  = LOCK_TMO_W + 1;

    localparam logic [PLL_CW-1:0] PLL_LAST = PLL_CW'(PLL_RST_CYC - 1);
    localparam logic [FILT_W-1:0] FILT_MAX = FILT_W'(2 ** LOCK_FILT);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'((2 ** LOCK_TMO_W) - 1);

    state_t             state, state_nxt;
    logic [PLL_CW-1:0]  pll_cnt, pll_cnt_nxt;
    logic [FILT_W-1:0]  filt_cnt, filt_cnt_nxt;
    logic [STG_W-1:0]   stg_cnt, stg_cnt_nxt, stg_inc;
    logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_nxt;
    logic               prn_nxt, rdy_nxt, ll_nxt;
    logic [N_RST-1:0]   rst_nxt;
    logic [3:0]         rc_nxt;
    logic               lock_s, lock_ok;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign lock_ok = (filt_cnt == FILT_MAX);

    // Lock filter: any low sample restarts the count; held clear while the
    // PLL is in reset so a stale lock never qualifies.
    always_comb begin
        filt_cnt_nxt = filt_cnt;
        if (state == PLL_RST || !lock_s)
            filt_cnt_nxt = '0;
        else if (!lock_ok)
            filt_cnt_nxt = filt_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= PLL_RST;
            pll_cnt     <= '0;
            filt_cnt    <= '0;
            stg_cnt     <= '0;
            tmo_cnt     <= '0;
            pll_reset_n <= 1'b0;
            rst_out     <= '1;
            ready       <= 1'b0;
            lock_lost   <= 1'b0;
            retry_cnt   <= 4'd0;
        end else begin
            state       <= state_nxt;
            pll_cnt     <= pll_cnt_nxt;
            filt_cnt    <= filt_cnt_nxt;
            stg_cnt     <= stg_cnt_nxt;
            tmo_cnt     <= tmo_cnt_nxt;
            pll_reset_n <= prn_nxt;
            rst_out     <= rst_nxt;
            ready       <= rdy_nxt;
            lock_lost   <= ll_nxt;
            retry_cnt   <= rc_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pll_cnt_nxt = pll_cnt;
        stg_cnt_nxt = stg_cnt;
        tmo_cnt_nxt = tmo_cnt;
        prn_nxt     = pll_reset_n;
        rst_nxt     = rst_out;
        rdy_nxt     = ready;
        ll_nxt      = lock_lost;
        rc_nxt      = retry_cnt;
        stg_inc     = (stg_cnt == '1) ? stg_cnt : stg_cnt + 1'b1;

        if (sw_rst_req) begin
            state_nxt   = PLL_RST;
            pll_cnt_nxt = '0;
            prn_nxt     = 1'b0;
            rst_nxt     = '1;
            rdy_nxt     = 1'b0;
            ll_nxt      = 1'b0;
        end else if (!lock_s && (state == RELEASE || state == RUN)) begin
            // No filtering on the way down: one low sample drops everything,
            // but the PLL itself is left running.
            state_nxt   = WAIT_LOCK;
            tmo_cnt_nxt = '0;
            prn_nxt     = 1'b1;
            rst_nxt     = '1;
            rdy_nxt     = 1'b0;
            ll_nxt      = 1'b1;
        end else begin
            case (state)
                PLL_RST: begin
                    prn_nxt = 1'b0;
                    rst_nxt = '1;
                    rdy_nxt = 1'b0;
                    if (pll_cnt == PLL_LAST) begin
                        state_nxt   = WAIT_LOCK;
                        tmo_cnt_nxt = '0;
                        prn_nxt     = 1'b1;
                    end else begin
                        pll_cnt_nxt = pll_cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    prn_nxt = 1'b1;
                    rst_nxt = '1;
                    rdy_nxt = 1'b0;
                    if (lock_ok) begin
                        state_nxt   = RELEASE;
                        stg_cnt_nxt = '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state_nxt   = PLL_RST;
                        pll_cnt_nxt = '0;
                        prn_nxt     = 1'b0;
                        if (retry_cnt != 4'hF)
                            rc_nxt = retry_cnt + 1'b1;
                    end else begin
                        tmo_cnt_nxt = tmo_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    stg_cnt_nxt = stg_inc;
                    // rst_nxt starts from rst_out, so a released bit stays low.
                    for (int i = 0; i < N_RST; i++)
                        if (stg_inc >= STG_W'((i + 1) << STAGE_DLY_W))
                            rst_nxt[i] = 1'b0;
                    if (!rst_nxt[N_RST-1]) begin
                        state_nxt = RUN;
                        rdy_nxt   = 1'b1;
                    end
                end
                RUN: begin
                    rst_nxt = '0;
                    rdy_nxt = 1'b1;
                end
                default: begin
                    state_nxt   = PLL_RST;
                    pll_cnt_nxt = '0;
                    prn_nxt     = 1'b0;
                    rst_nxt     = '1;
                    rdy_nxt     = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysmgr_rst_seq.sv
// Bench for sysmgr_rst_seq (N_RST=3, PLL_RST_CYC=4, LOCK_FILT=2,
// STAGE_DLY_W=2, LOCK_TMO_W=6). Each table row gives the cycle offset (edges
// since rst_n release), the inputs driven after that edge, and the outputs
// expected right after that edge.
module tb_sysmgr_rst_seq;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       pll_lock   = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       pll_reset_n;
    logic [2:0] rst_out;
    logic       ready;
    logic       lock_lost;
    logic [3:0] retry_cnt;

    int cyc    = 0;
    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        int         dc;
        logic       lock;
        logic       sw;
        logic       prn;
        logic [2:0] ro;
        logic       rdy;
        logic       ll;
        logic [3:0] rc;
        string      nm;
    } vec_t;

    typedef struct {
        int         cyc;
        logic       prn;
        logic [2:0] ro;
        logic       rdy;
        logic       ll;
        logic [3:0] rc;
        string      nm;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];

    sysmgr_rst_seq #(
        .N_RST(3), .PLL_RST_CYC(4), .LOCK_FILT(2), .STAGE_DLY_W(2), .LOCK_TMO_W(6)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pll_lock    (pll_lock),
        .sw_rst_req  (sw_rst_req),
        .pll_reset_n (pll_reset_n),
        .rst_out     (rst_out),
        .ready       (ready),
        .lock_lost   (lock_lost),
        .retry_cnt   (retry_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic prn, input logic [2:0] ro,
                       input logic rdy, input logic ll, input logic [3:0] rc);
        n_vec++;
        if (pll_reset_n !== prn || rst_out !== ro || ready !== rdy ||
            lock_lost !== ll || retry_cnt !== rc) begin
            n_miss++;
            $display("FAIL %s cyc=%0d got prn=%b rst_out=%b ready=%b lock_lost=%b retry=%0d want prn=%b rst_out=%b ready=%b lock_lost=%b retry=%0d",
                     nm, cyc, pll_reset_n, rst_out, ready, lock_lost, retry_cnt,
                     prn, ro, rdy, ll, rc);
        end
    endtask

    // Scoreboard consumer: compares the head entry on the sample edge it names.
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            if (e.cyc < cyc) begin
                n_vec++;
                n_miss++;
                $display("FAIL %s sample missed: now cyc=%0d, wanted cyc=%0d", e.nm, cyc, e.cyc);
            end else begin
                chk(e.nm, e.prn, e.ro, e.rdy, e.ll, e.rc);
            end
        end
    end

    task automatic add(input int dc, input logic lk, input logic sw, input logic prn,
                       input logic [2:0] ro, input logic rdy, input logic ll,
                       input logic [3:0] rc, input string nm);
        vec_t v;
        v.dc = dc; v.lock = lk; v.sw = sw; v.prn = prn; v.ro = ro;
        v.rdy = rdy; v.ll = ll; v.rc = rc; v.nm = nm;
        tbl.push_back(v);
    endtask

    task automatic run_table(input int base);
        exp_t e;
        for (int i = 0; i < tbl.size(); i++) begin
            e.cyc = base + tbl[i].dc; e.prn = tbl[i].prn; e.ro = tbl[i].ro;
            e.rdy = tbl[i].rdy; e.ll = tbl[i].ll; e.rc = tbl[i].rc; e.nm = tbl[i].nm;
            sbq.push_back(e);
            while (cyc < base + tbl[i].dc) @(negedge clk);
            pll_lock   = tbl[i].lock;
            sw_rst_req = tbl[i].sw;
        end
        for (int k = 0; k < 4 && sbq.size() > 0; k++) @(negedge clk);
        if (sbq.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain %0d expectations left unchecked", sbq.size());
            sbq.delete();
        end
        tbl.delete();
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        chk("reset_state", 1'b0, 3'b111, 1'b0, 1'b0, 4'd0);

        // Power-up with lock at cycle 10, lock drop in RUN, sw requests.
        add(  1, 0, 0, 0, 3'b111, 0, 0, 0, "pllrst_e1");
        add(  3, 0, 0, 0, 3'b111, 0, 0, 0, "pllrst_e3");
        add(  4, 0, 0, 1, 3'b111, 0, 0, 0, "pllrst_done");
        add( 10, 1, 0, 1, 3'b111, 0, 0, 0, "lock_rise");
        add( 16, 1, 0, 1, 3'b111, 0, 0, 0, "filt_sat");
        add( 20, 1, 0, 1, 3'b111, 0, 0, 0, "rel_pre0");
        add( 21, 1, 0, 1, 3'b110, 0, 0, 0, "rel_bit0");
        add( 24, 1, 0, 1, 3'b110, 0, 0, 0, "rel_pre1");
        add( 25, 1, 0, 1, 3'b100, 0, 0, 0, "rel_bit1");
        add( 28, 1, 0, 1, 3'b100, 0, 0, 0, "rel_pre2");
        add( 29, 1, 0, 1, 3'b000, 1, 0, 0, "run_entry");
        add( 40, 0, 0, 1, 3'b000, 1, 0, 0, "run_drop");
        add( 41, 1, 0, 1, 3'b000, 1, 0, 0, "run_relock");
        add( 42, 1, 0, 1, 3'b000, 1, 0, 0, "loss_pre");
        add( 43, 1, 0, 1, 3'b111, 0, 1, 0, "loss_rise");
        add( 47, 1, 0, 1, 3'b111, 0, 1, 0, "relock_filt");
        add( 51, 1, 0, 1, 3'b111, 0, 1, 0, "relock_pre0");
        add( 52, 1, 0, 1, 3'b110, 0, 1, 0, "relock_bit0");
        add( 53, 1, 1, 1, 3'b110, 0, 1, 0, "sw_drive");
        add( 54, 1, 0, 0, 3'b111, 0, 0, 0, "sw_reset");
        add( 57, 1, 0, 0, 3'b111, 0, 0, 0, "sw_pll_low");
        add( 58, 1, 0, 1, 3'b111, 0, 0, 0, "sw_pll_high");
        add( 66, 1, 0, 1, 3'b111, 0, 0, 0, "sw_rel_pre0");
        add( 67, 1, 0, 1, 3'b110, 0, 0, 0, "sw_rel_bit0");
        add( 71, 1, 0, 1, 3'b100, 0, 0, 0, "sw_rel_bit1");
        add( 75, 1, 0, 1, 3'b000, 1, 0, 0, "sw_run");
        add( 79, 1, 1, 1, 3'b000, 1, 0, 0, "sw2_drive");
        add( 80, 1, 0, 0, 3'b111, 0, 0, 0, "sw2_reset");
        add( 81, 1, 1, 0, 3'b111, 0, 0, 0, "sw3_drive");
        add( 82, 1, 0, 0, 3'b111, 0, 0, 0, "sw3_restart");
        add( 84, 1, 0, 0, 3'b111, 0, 0, 0, "restart_hold");
        add( 85, 1, 0, 0, 3'b111, 0, 0, 0, "restart_last");
        add( 86, 1, 0, 1, 3'b111, 0, 0, 0, "restart_done");
        add( 94, 1, 0, 1, 3'b111, 0, 0, 0, "rs_pre0");
        add( 95, 1, 0, 1, 3'b110, 0, 0, 0, "rs_bit0");
        add( 99, 1, 0, 1, 3'b100, 0, 0, 0, "rs_bit1");
        add(102, 1, 0, 1, 3'b100, 0, 0, 0, "rs_pre2");
        add(103, 1, 0, 1, 3'b000, 1, 0, 0, "rs_run");
        rst_n = 1'b1;
        base  = cyc;
        run_table(base);

        // Asynchronous reset from RUN, mid-cycle.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_run", 1'b0, 3'b111, 1'b0, 1'b0, 4'd0);
        @(negedge clk);

        // Full sequence again with lock already high.
        add( 1, 1, 0, 0, 3'b111, 0, 0, 0, "re_pll_e1");
        add( 3, 1, 0, 0, 3'b111, 0, 0, 0, "re_pll_e3");
        add( 4, 1, 0, 1, 3'b111, 0, 0, 0, "re_wait");
        add( 8, 1, 0, 1, 3'b111, 0, 0, 0, "re_filt");
        add(12, 1, 0, 1, 3'b111, 0, 0, 0, "re_pre0");
        add(13, 1, 0, 1, 3'b110, 0, 0, 0, "re_bit0");
        add(17, 1, 0, 1, 3'b100, 0, 0, 0, "re_bit1");
        add(20, 1, 0, 1, 3'b100, 0, 0, 0, "re_pre2");
        add(21, 1, 0, 1, 3'b000, 1, 0, 0, "re_run");
        rst_n = 1'b1;
        base  = cyc;
        run_table(base);

        @(posedge clk);
        #2 rst_n = 1'b0;
        pll_lock = 1'b0;
        #1 chk("async_rst_run2", 1'b0, 3'b111, 1'b0, 1'b0, 4'd0);
        @(negedge clk);

        // No lock: short glitch must not release, then timeouts and saturation.
        add(   1, 0, 0, 0, 3'b111, 0, 0,  0, "nl_pll_e1");
        add(   4, 0, 0, 1, 3'b111, 0, 0,  0, "nl_wait");
        add(  10, 1, 0, 1, 3'b111, 0, 0,  0, "glitch_hi");
        add(  13, 0, 0, 1, 3'b111, 0, 0,  0, "glitch_lo");
        add(  16, 0, 0, 1, 3'b111, 0, 0,  0, "glitch_after");
        add(  30, 0, 0, 1, 3'b111, 0, 0,  0, "glitch_quiet");
        add(  67, 0, 0, 1, 3'b111, 0, 0,  0, "tmo_pre");
        add(  68, 0, 0, 0, 3'b111, 0, 0,  1, "tmo_retry1");
        add(  71, 0, 0, 0, 3'b111, 0, 0,  1, "retry_pll_low");
        add(  72, 0, 0, 1, 3'b111, 0, 0,  1, "retry_pll_high");
        add( 135, 0, 0, 1, 3'b111, 0, 0,  1, "tmo2_pre");
        add( 136, 0, 0, 0, 3'b111, 0, 0,  2, "tmo_retry2");
        add(1019, 0, 0, 1, 3'b111, 0, 0, 14, "tmo15_pre");
        add(1020, 0, 0, 0, 3'b111, 0, 0, 15, "tmo_retry15");
        add(1087, 0, 0, 1, 3'b111, 0, 0, 15, "tmo16_pre");
        add(1088, 0, 0, 0, 3'b111, 0, 0, 15, "retry_sat16");
        add(1156, 0, 0, 0, 3'b111, 0, 0, 15, "retry_sat17");
        rst_n = 1'b1;
        base  = cyc;
        run_table(base);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
